ram: RTL and testbench
======================

Name: ram

Overview:
- 256 x 8 single-port RAM attached to the processor's shared 8-bit tri-state data bus.
- An internal memory address register (MAR) is loaded from a dedicated address input.
- Writes capture the bus into the addressed word. Reads drive the addressed word onto the bus.
- Control strobes are level signals sampled on the clock; the bus is driven only while reading.

Parameters:
ADDR_W, 8, address width; MAR width.
DATA_W, 8, data word and bus width.
DEPTH, 256, number of words (2**ADDR_W).

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
a  input  ADDR_W  address value to latch into MAR.
sa  input  1  set address: load MAR from a.
s  input  1  set data: write bus into mem[MAR].
e  input  1  enable: drive mem[MAR] onto bus.
bus  inout  DATA_W  shared tri-state data bus.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - MAR clears to 0.
  - bus is high-Z immediately.
  - No write occurs while reset is asserted.
  - Memory contents are not cleared and are preserved across reset; power-up contents are undefined (X).
- MAR update: on a rising clk edge with sa=1, MAR <= a. With sa=0, MAR holds.
- Write: on a rising clk edge with s=1, mem[MAR] <= bus, using the MAR value before that edge.
- Simultaneous sa=1 and s=1: the write goes to the old MAR; MAR takes a after the same edge.
- Read is combinational. bus = mem[MAR] while e=1, s=0, rst_n=1; otherwise bus = high-Z.
  - Data appears on bus in the same cycle e rises; there is no clock latency.
  - Read data updates combinationally when MAR or the addressed word changes.
  - A word written at edge N is visible on bus right after edge N.
- s=1 and e=1 together: the write has priority. The RAM does not drive bus, which avoids contention, and the write proceeds.
- Addresses cover the full 0..255 range; there is no out-of-range condition. Data is stored unmodified, 8-bit.
- The RAM never drives bus while s=1; the external writer owns the bus then.

Decomposition:
- Shared package holds ADDR_W, DATA_W and DEPTH constants, plus a data word typedef (logic [DATA_W-1:0]) and an address typedef.
- One natural sub-module, ram_array:
  - Synchronous-write, asynchronous-read storage array with ports clk, we, waddr/raddr, wdata and rdata; no reset.
- The top level holds:
  - the MAR register with async reset;
  - the write and read gating;
  - the tri-state bus driver.

Test Plan:
- Fill/readback: for i=0..255, pulse sa with a=i, then pulse s with bus driven to (i+1) mod 256. Then for i=0..255, pulse sa and raise e. Required: bus reads i+1; address 255 reads 0x00.
- Idle bus: with e=0 and s=0 at any MAR, bus must be Z. Raise e with MAR=5 holding 0x06: bus must read 0x06 before the next clk edge.
- Simultaneous sa+s: MAR=3, a=9, bus=0xAA, sa=s=1 for one edge. Required: mem[3]=0xAA, mem[9] unchanged, MAR=9 afterwards.
- Write/read conflict: s=1 and e=1 with MAR=7 and external bus 0x55. Required: RAM never drives bus (no X from contention) and mem[7]=0x55.
- Mid-operation reset: MAR=0x20 holding 0x21 with e=1, then drop rst_n asynchronously between edges. Required:
  - bus goes Z immediately and MAR=0;
  - an s pulse held during reset leaves memory unchanged;
  - after release, a read at address 0x20 still returns 0x21.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared sizing constants and word/address types for the bus-attached RAM.
package ram_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/ram_if.sv
// Control strobes and address for the RAM; the data bus itself stays a net port on the RAM.
interface ram_if;
  import ram_pkg::*;
  addr_t a;
  logic  sa;
  logic  s;
  logic  e;

  modport master (output a, sa, s, e);
  modport slave  (input  a, sa, s, e);
endinterface

// File: rtl/ram_array.sv
// Storage array: synchronous write, asynchronous read, no reset on contents.
module ram_array
  import ram_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  addr_t raddr,
  input  data_t wdata,
  output data_t rdata
);
  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ram.sv
// 256x8 RAM on a shared tri-state bus: MAR load, bus write, combinational bus read.
module ram
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ram_if.slave              ctl,
  inout  wire  [DATA_W-1:0] bus
);
  addr_t mar;
  data_t rdata;
  logic  we;
  logic  rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mar <= '0;
    else if (ctl.sa) mar <= ctl.a;
  end

  // Writer owns the bus whenever s is high, so reads back off; reset blocks both.
  assign we    = ctl.s & rst_n;
  assign rd_en = ctl.e & ~ctl.s & rst_n;
  assign bus   = rd_en ? rdata : {DATA_W{1'bz}};

  ram_array u_array (
    .clk   (clk),
    .we    (we),
    .waddr (mar),
    .raddr (mar),
    .wdata (bus),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_ram.sv
// Scoreboarded bench for ram: bus is pulled up so an undriven bus reads 8'hFF.
module tb_ram;
  logic       clk;
  logic       rst_n;
  logic       drv;
  logic [7:0] drv_d;
  wire  [7:0] bus;

  ram_if rif ();

  ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (rif),
    .bus   (bus)
  );

  assign bus = drv ? drv_d : 8'bz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (bus[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] mdl [256];
  logic [7:0] mar_m;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic set_addr(input logic [7:0] addr);
    @(negedge clk);
    rif.a  = addr;
    rif.sa = 1'b1;
    @(negedge clk);
    rif.sa = 1'b0;
    mar_m  = addr;
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    drv   = 1'b1;
    drv_d = d;
    rif.s = 1'b1;
    @(negedge clk);
    rif.s = 1'b0;
    drv   = 1'b0;
    mdl[mar_m] = d;
  endtask

  // Raise e mid-cycle and sample well before the next rising edge.
  task automatic rd(input string tag);
    @(negedge clk);
    rif.e = 1'b1;
    exp_q.push_back(mdl[mar_m]);
    #2;
    chk(tag, bus, exp_q.pop_front());
    #1 rif.e = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drv = 1'b0; drv_d = '0;
    rif.a = '0; rif.sa = 1'b0; rif.s = 1'b0; rif.e = 1'b1;
    mar_m = '0;
    #12;
    chk("reset_z", bus, 8'hFF);
    rif.e = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      set_addr(8'(i));
      wr(8'(i + 1));
    end
    for (int i = 0; i < 256; i++) begin
      set_addr(8'(i));
      rd($sformatf("fill_rd%0d", i));
    end

    // Idle bus with valid data at MAR must still be released.
    set_addr(8'd5);
    @(negedge clk);
    #2 chk("idle_z", bus, 8'hFF);
    rd("e_same_cycle");

    // Simultaneous sa+s: write lands at old MAR, MAR then follows a.
    set_addr(8'd3);
    @(negedge clk);
    rif.a = 8'd9; rif.sa = 1'b1; rif.s = 1'b1; drv = 1'b1; drv_d = 8'hAA;
    @(negedge clk);
    rif.sa = 1'b0; rif.s = 1'b0; drv = 1'b0;
    mdl[3] = 8'hAA; mar_m = 8'd9;
    rd("sim_mar9");
    set_addr(8'd3);
    rd("sim_mem3");

    // Write and read requested together: write wins, RAM stays off the bus.
    set_addr(8'd7);
    @(negedge clk);
    rif.s = 1'b1; rif.e = 1'b1; drv = 1'b1; drv_d = 8'h55;
    #2 chk("conflict_bus", bus, 8'h55);
    @(negedge clk);
    rif.s = 1'b0; rif.e = 1'b0; drv = 1'b0;
    mdl[7] = 8'h55;
    rd("conflict_mem7");

    // Mid-operation reset with a write attempt held through it.
    set_addr(8'h20);
    @(negedge clk);
    rif.e = 1'b1;
    #1 chk("rst_pre", bus, 8'h21);
    #1 rst_n = 1'b0;
    #1 chk("rst_bus_z", bus, 8'hFF);
    mar_m = '0;
    @(negedge clk);
    rif.e = 1'b0; rif.s = 1'b1; drv = 1'b1; drv_d = 8'h77;
    @(negedge clk);
    rif.s = 1'b0; drv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd("rst_mar0");
    set_addr(8'h20);
    rd("rst_keep20");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
